// File: rtl/cmp_pipe.sv
`timescale 1ns/1ps
// cmp_pipe: parametrised, pipelined integer compare unit for the execute stage.
//
// Compares in_a and in_b according to in_func when an operation is accepted,
// then carries the result through STAGES register slots with valid/ready
// handshakes, backpressure, flush and an opaque tag sideband.
//
// Optional feature macro: CMP_PIPE_MINMAX_EN
//   defined   : func 1100/1101/1110/1111 = MIN/MAX/MINU/MAXU, out_value = operand
//   undefined : those codes are illegal and out_value is tied to 0
//
// Parameters:
//   WIDTH  operand width (>=2)
//   STAGES register slots between input handshake and output (1..4)
//   TAG_W  sideband tag width (>=1)
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready has no path from in_valid)
//   in_a, in_b            operands
//   in_func               function select (bit0 negate, bit1 unsigned, bit2 less-than)
//   in_tag                tag returned unchanged with the result
//   flush                 kill all in-flight operations at the next edge
//   out_valid/out_ready   output handshake
//   out_flag              compare result
//   out_value             min/max operand, else 0
//   out_tag               tag of the result
//   out_illegal           function code was illegal
// All out_* payload ports read 0 whenever out_valid is 0.
module cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_flag,
  output logic [WIDTH-1:0] out_value,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int LAST = STAGES - 1;

  // compare primitives
  logic w_eq;
  logic w_lt;
  logic w_ltu;
  // decoded result for the operation at the input
  logic w_flag;
  logic w_illegal;
`ifdef CMP_PIPE_MINMAX_EN
  logic [WIDTH-1:0] w_value;
`endif

  // handshake control
  logic              w_accept;
  logic [STAGES-1:0] w_can_load;

  // slot state; index LAST drives the outputs
  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0]            r_flag;
  logic [STAGES-1:0]            r_illegal;
  logic [STAGES-1:0][TAG_W-1:0] r_tag;
`ifdef CMP_PIPE_MINMAX_EN
  logic [STAGES-1:0][WIDTH-1:0] r_value;
`endif

  // Shared equality / signed / unsigned less-than on the input operands.
  always_comb begin
    w_eq  = (in_a == in_b);
    w_lt  = ($signed(in_a) < $signed(in_b));
    w_ltu = (in_a < in_b);
  end

  // Function decode: select flag (and operand for min/max); unknown codes are illegal.
  always_comb begin
    w_flag    = 1'b0;
    w_illegal = 1'b0;
`ifdef CMP_PIPE_MINMAX_EN
    w_value   = {WIDTH{1'b0}};
`endif
    case (in_func)
      4'b0000: w_flag = w_eq;
      4'b0001: w_flag = ~w_eq;
      4'b0100: w_flag = w_lt;
      4'b0101: w_flag = ~w_lt;
      4'b0110: w_flag = w_ltu;
      4'b0111: w_flag = ~w_ltu;
`ifdef CMP_PIPE_MINMAX_EN
      // min/max report (a<b) as the flag regardless of which operand is picked
      4'b1100: begin
        w_flag  = w_lt;
        w_value = w_lt ? in_a : in_b;
      end
      4'b1101: begin
        w_flag  = w_lt;
        w_value = w_lt ? in_b : in_a;
      end
      4'b1110: begin
        w_flag  = w_ltu;
        w_value = w_ltu ? in_a : in_b;
      end
      4'b1111: begin
        w_flag  = w_ltu;
        w_value = w_ltu ? in_b : in_a;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // Slot k can load if out_ready is high or any slot from k to the output is
  // empty; a running OR avoids a self-referencing vector.
  always_comb begin
    logic v_room;
    w_can_load = {STAGES{1'b0}};
    v_room     = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      v_room        = v_room | ~r_valid[k];
      w_can_load[k] = v_room;
    end
  end

  assign in_ready = w_can_load[0] & ~flush;
  assign w_accept = in_valid & in_ready;

  // Slot valid bits: flush empties everything, otherwise each loadable slot
  // takes the valid of its upstream neighbour (slot 0 takes the accept).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= {STAGES{1'b0}};
    end else if (flush) begin
      r_valid <= {STAGES{1'b0}};
    end else begin
      if (w_can_load[0]) begin
        r_valid[0] <= w_accept;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_can_load[k]) begin
          r_valid[k] <= r_valid[k-1];
        end
      end
    end
  end

  // Slot payloads: only move when real data moves; empty slots may keep stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag    <= {STAGES{1'b0}};
      r_illegal <= {STAGES{1'b0}};
      r_tag     <= {(STAGES*TAG_W){1'b0}};
`ifdef CMP_PIPE_MINMAX_EN
      r_value   <= {(STAGES*WIDTH){1'b0}};
`endif
    end else begin
      if (w_accept) begin
        r_flag[0]    <= w_flag;
        r_illegal[0] <= w_illegal;
        r_tag[0]     <= in_tag;
`ifdef CMP_PIPE_MINMAX_EN
        r_value[0]   <= w_value;
`endif
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_can_load[k] && r_valid[k-1]) begin
          r_flag[k]    <= r_flag[k-1];
          r_illegal[k] <= r_illegal[k-1];
          r_tag[k]     <= r_tag[k-1];
`ifdef CMP_PIPE_MINMAX_EN
          r_value[k]   <= r_value[k-1];
`endif
        end
      end
    end
  end

  // Output gating: the last slot drives the ports, forced to 0 while it is empty.
  assign out_valid   = r_valid[LAST];
  assign out_flag    = r_valid[LAST] & r_flag[LAST];
  assign out_illegal = r_valid[LAST] & r_illegal[LAST];
  assign out_tag     = r_valid[LAST] ? r_tag[LAST] : {TAG_W{1'b0}};
`ifdef CMP_PIPE_MINMAX_EN
  assign out_value   = r_valid[LAST] ? r_value[LAST] : {WIDTH{1'b0}};
`else
  assign out_value   = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
`timescale 1ns/1ps
// Testbench for cmp_pipe (WIDTH=32, STAGES=2, TAG_W=5).
// A queue-based reference model predicts every delivered result; directed
// sequences add literal expectations for latency, backpressure, flush,
// illegal codes, min/max and asynchronous reset.
module tb_cmp_pipe;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [3:0]    in_func;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_flag;
  logic [W-1:0]  out_value;
  logic [TW-1:0] out_tag;
  logic          out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  cmp_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_func    (in_func),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flag   (out_flag),
    .out_value  (out_value),
    .out_tag    (out_tag),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          flag;
    logic [W-1:0]  value;
    logic [TW-1:0] tag;
    logic          illegal;
  } exp_t;

  exp_t q[$];

  task automatic checkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checkv(name, {63'd0, act}, {63'd0, exp});
  endtask

  // Reference: results from the function table with 64-bit integer arithmetic.
  function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] t);
    exp_t   e;
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    e.flag = 1'b0; e.value = 32'h0; e.tag = t; e.illegal = 1'b0;
    case (f)
      4'b0000: e.flag = (ua == ub);
      4'b0001: e.flag = (ua != ub);
      4'b0100: e.flag = (sa < sb);
      4'b0101: e.flag = (sa >= sb);
      4'b0110: e.flag = (ua < ub);
      4'b0111: e.flag = (ua >= ub);
`ifdef CMP_PIPE_MINMAX_EN
      4'b1100: begin e.flag = (sa < sb); e.value = (sa <= sb) ? a : b; end
      4'b1101: begin e.flag = (sa < sb); e.value = (sa >= sb) ? a : b; end
      4'b1110: begin e.flag = (ua < ub); e.value = (ua <= ub) ? a : b; end
      4'b1111: begin e.flag = (ua < ub); e.value = (ua >= ub) ? a : b; end
`endif
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Compare process: at every negedge check delivered results against the model queue.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_out: out_valid=1 tag=%0h, expected nothing pending", out_tag);
        end else begin
          if ({out_flag, out_value, out_tag, out_illegal} !== q[0]) begin
            n_fail++;
            $display("FAIL model_out: got flag=%0b value=%0h tag=%0h illegal=%0b, expected flag=%0b value=%0h tag=%0h illegal=%0b",
                     out_flag, out_value, out_tag, out_illegal,
                     q[0].flag, q[0].value, q[0].tag, q[0].illegal);
          end
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        checkv("idle_zero", {25'd0, out_flag, out_value, out_tag, out_illegal}, 64'd0);
      end
      if (flush) begin
        check1("flush_in_ready", in_ready, 1'b0);
        q.delete();
      end
      if (in_valid && in_ready) q.push_back(model(in_func, in_a, in_b, in_tag));
    end
  end

  task automatic drive(input logic v, input logic [3:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] t);
    in_valid = v; in_func = f; in_a = a; in_b = b; in_tag = t;
  endtask

  // One op with out_ready=1; returns at the cycle its result is visible.
  task automatic run_one(input logic [3:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] t);
    @(posedge clk); #1;
    drive(1'b1, f, a, b, t);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [3:0]   s_func [8] = '{4'b0000, 4'b0001, 4'b0101, 4'b0111, 4'b0100, 4'b0110, 4'b0000, 4'b0101};
  logic [W-1:0] s_a    [8] = '{32'd5, 32'd5, 32'hFFFFFFFE, 32'd0, 32'd3, 32'd3, 32'd7, 32'h80000000};
  logic [W-1:0] s_b    [8] = '{32'd5, 32'd6, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd8, 32'h7FFFFFFF};
  logic         s_flag [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // Watchdog: the run must always end.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, first, last, acc, got;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    checkv("rst_out_tag", {59'd0, out_tag}, 64'd0);
    reset = 1'b0;
    #1;
    check1("rst_in_ready", in_ready, 1'b1);

    // Latency: signed vs unsigned less-than on -1 vs 1.
    @(posedge clk); #1;
    drive(1'b1, 4'b0100, 32'hFFFFFFFF, 32'd1, 5'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1("t1_not_yet", out_valid, 1'b0);
    @(posedge clk); #1;
    check1("t1_valid", out_valid, 1'b1);
    check1("t1_lt_flag", out_flag, 1'b1);
    checkv("t1_tag", {59'd0, out_tag}, 64'd3);
    drive(1'b1, 4'b0110, 32'hFFFFFFFF, 32'd1, 5'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check1("t1u_valid", out_valid, 1'b1);
    check1("t1u_ltu_flag", out_flag, 1'b0);
    checkv("t1u_tag", {59'd0, out_tag}, 64'd4);

    // Back-to-back stream of 8 ops.
    idx = 0; first = -1; last = -1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (idx < 8) begin
          check1("t2_flag", out_flag, s_flag[idx]);
          checkv("t2_tag", {59'd0, out_tag}, 64'(idx));
        end
        if (first < 0) first = c;
        last = c;
        idx++;
      end
      if (c < 8) begin
        check1("t2_in_ready", in_ready, 1'b1);
        drive(1'b1, s_func[c], s_a[c], s_b[c], 5'(c));
      end else begin
        in_valid = 1'b0;
      end
    end
    checkv("t2_count", 64'(idx), 64'd8);
    checkv("t2_consecutive", 64'(last - first), 64'd7);

    // Backpressure: out_ready low for 6 cycles while offering 4 ops.
    acc = 0; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin
        checkv("t3_accepted", 64'(acc), 64'd2);
        check1("t3_full_ready", in_ready, 1'b0);
      end
      if (out_valid && c < 6) begin
        checkv("t3_stable_tag", {59'd0, out_tag}, 64'd10);
        check1("t3_stable_flag", out_flag, 1'b1);
      end
      out_ready = (c >= 6);
      #1;
      if (out_valid && out_ready) begin
        checkv("t3_order_tag", {59'd0, out_tag}, 64'(10 + got));
        check1("t3_order_flag", out_flag, (got < 2));
        got++;
      end
      if (acc < 4) begin
        drive(1'b1, 4'b0110, 32'(acc), 32'd2, 5'(10 + acc));
        #1;
        if (in_ready) acc++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkv("t3_delivered", 64'(got), 64'd4);

    // Flush a full pipeline while offering an op.
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (in_ready) drive(1'b1, 4'b0000, 32'(c), 32'(c), 5'(20 + c));
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;
    check1("t4_full_valid", out_valid, 1'b1);
    flush = 1'b1;
    drive(1'b1, 4'b0100, 32'd1, 32'd2, 5'd30);
    #1;
    check1("t4_ready_in_flush", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check1("t4_empty", out_valid, 1'b0);
    out_ready = 1'b1;
    #1;
    check1("t4_ready_after", in_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check1("t4_no_leak", out_valid, 1'b0);
    end

    // Illegal code.
    run_one(4'b0010, 32'h12, 32'h12, 5'd7);
    check1("t5_valid", out_valid, 1'b1);
    check1("t5_illegal", out_illegal, 1'b1);
    check1("t5_flag", out_flag, 1'b0);
    checkv("t5_value", {32'd0, out_value}, 64'd0);
    checkv("t5_tag", {59'd0, out_tag}, 64'd7);
`ifdef CMP_PIPE_MINMAX_EN
    run_one(4'b1100, 32'hFFFFFFFD, 32'd4, 5'd8);
    checkv("t5_min_value", {32'd0, out_value}, 64'hFFFFFFFD);
    check1("t5_min_flag", out_flag, 1'b1);
    check1("t5_min_legal", out_illegal, 1'b0);
    run_one(4'b1110, 32'hFFFFFFFD, 32'd4, 5'd9);
    checkv("t5_minu_value", {32'd0, out_value}, 64'd4);
    check1("t5_minu_flag", out_flag, 1'b0);
    run_one(4'b1101, 32'hFFFFFFFD, 32'd4, 5'd10);
    checkv("t5_max_value", {32'd0, out_value}, 64'd4);
`else
    run_one(4'b1100, 32'hFFFFFFFD, 32'd4, 5'd8);
    check1("t5_min_illegal", out_illegal, 1'b1);
    checkv("t5_min_value0", {32'd0, out_value}, 64'd0);
    check1("t5_min_flag0", out_flag, 1'b0);
`endif

    // Asynchronous reset with two ops in flight.
    @(posedge clk); #1;
    drive(1'b1, 4'b0000, 32'd9, 32'd9, 5'd17);
    @(posedge clk); #1;
    drive(1'b1, 4'b0001, 32'd1, 32'd2, 5'd18);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1("t6_inflight", out_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1("t6_rst_valid", out_valid, 1'b0);
    check1("t6_rst_flag", out_flag, 1'b0);
    checkv("t6_rst_tag", {59'd0, out_tag}, 64'd0);
    checkv("t6_rst_value", {32'd0, out_value}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check1("t6_ready_after", in_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check1("t6_no_stale", out_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
Parametrised, pipelined integer compare unit for the execute stage; the successor to the single-cycle branch comparator.
- Generalised in operand width and pipeline depth.
- Adds valid/ready handshakes with backpressure, a flush input, a tag sideband and illegal-function reporting.
- Optional value-producing min/max operations (Zbb-style).
- Feeds branch resolution (flag) and the ALU writeback mux (value).

Parameters:
WIDTH, 32, operand width in bits (>=2).
STAGES, 2, number of register stages between input handshake and output (1..4).
TAG_W, 5, width of the sideband tag carried alongside each operation (>=1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous active-high reset.
in_valid  in  1  operation offered.
in_ready  out  1  unit can accept this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_func  in  4  function select.
in_tag  in  TAG_W  opaque tag, returned unchanged.
flush  in  1  kill all in-flight operations.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
out_flag  out  1  compare result.
out_value  out  WIDTH  selected operand (min/max), else 0.
out_tag  out  TAG_W  tag of the result.
out_illegal  out  1  function code was illegal.

Behaviour:
- Function encoding, in_func[3:0]:
  - 0000 EQ, 0001 NE, 0100 LT, 0101 GE, 0110 LTU, 0111 GEU.
  - bit0 = negate, bit1 = unsigned, bit2 = less-than (else equality).
  - 1100 MIN, 1101 MAX, 1110 MINU, 1111 MAXU, only with the optional feature.
  - All other codes are illegal.
- Compare evaluation:
  - Evaluated combinationally on in_a/in_b at acceptance and captured into stage 0.
  - Signed ops use two's complement over WIDTH bits.
  - EQ/NE/LT/GE/LTU/GEU: flag = result, value = 0.
  - MIN/MINU: value = smaller operand, flag = (a<b). MAX/MAXU: value = larger operand, flag = (a<b).
  - Illegal code: flag = 0, value = 0, illegal = 1, tag still carried.
- Pipeline:
  - STAGES slots, each holding valid + payload; the last slot drives the out_* ports.
  - A slot loads when it is empty or its contents move on in the same cycle.
  - The last slot moves on when out_ready=1.
  - in_ready = slot 0 can load. It is combinational from out_ready through the slot valids; no combinational path from in_valid.
  - Accept = in_valid & in_ready.
- Latency: with out_ready held at 1, an operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1. Throughput is 1 op per cycle.
- Backpressure:
  - With out_ready=0, the pipeline fills to STAGES entries, then in_ready=0.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - Order is preserved; no drops and no duplicates.
- Flush:
  - At the next edge, all slot valids clear.
  - An operation offered in the flush cycle is not accepted (in_ready forced 0 while flush=1).
  - The out_valid/out_ready transfer in the flush cycle still completes for the consumer.
  - The pipeline is empty on the following cycle.
- Reset:
  - Asynchronous; all valids cleared. out_flag, out_value, out_tag and out_illegal reset to 0.
  - Mid-operation reset discards all in-flight work.
  - in_ready = 1 after reset deasserts.
- Payload registers of empty slots may hold stale data, but out_* are 0 whenever out_valid=0 (output-gated).

Optional Feature:
- Macro: CMP_PIPE_MINMAX_EN.
- Defined: codes 1100–1111 perform MIN/MAX/MINU/MAXU as above, and out_value carries the operand.
- Undefined:
  - Those codes are illegal (flag 0, value 0, illegal 1).
  - No value mux is built; out_value is tied to 0.

Test Plan:
- STAGES=2, WIDTH=32, out_ready=1, in_func=0100, a=32'hFFFFFFFF, b=1, tag=3 -> 2 cycles later out_valid=1, flag=1, tag=3; same with func 0110 -> flag=0.
- Back-to-back stream of 8 ops (EQ a=b=5, NE a=5 b=6, GE a=-2 b=-2, GEU a=0 b=1, ...) -> 8 consecutive results in order, flags 1,1,1,0,..., in_ready never drops.
- out_ready=0 while feeding 4 ops with STAGES=2 -> exactly 2 accepted, in_ready=0 after, outputs stable. Release -> both delivered in order, then the remaining 2 accepted.
- Pipeline full, flush=1 with in_valid=1 for one cycle -> next cycle out_valid=0, flushed op not accepted, in_ready=1.
- in_func=0010 tag=7 -> out_illegal=1, flag=0, value=0, tag=7. With CMP_PIPE_MINMAX_EN, func=1100 a=-3 b=4 -> value=32'hFFFFFFFD; func=1110 -> value=4. Without the macro, func=1100 -> illegal=1.
- Assert reset asynchronously with 2 ops in flight -> out_valid=0 and outputs 0 immediately; after release in_ready=1 and no stale result emerges.
